// File: rtl/arc4_engine.sv
// ARC4 decryption engine: owns a 256x8 S-box, runs init / key schedule /
// optional RC4-drop[n] discard, then decrypts a length-prefixed ct buffer to pt.
module arc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);
  localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [11:0]       DROP_LAST = 12'(DROP_N - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_INIT = 3'd1, ST_KSA = 3'd2, ST_DROP = 3'd3,
    ST_LEN  = 3'd4, ST_PRGA = 3'd5, ST_DONE = 3'd6
  } state_t;

  state_t                 state_r, state_s;
  logic [2:0]             phase_r, phase_s;
  logic [7:0]             i_r, j_r, si_r, sj_r, k_r, len_r;
  logic [KIDX_W-1:0]      kidx_r;
  logic [11:0]            drop_cnt_r;
  logic [8*KEY_BYTES-1:0] key_r;
  logic                   rdy_r, pt_wren_r;
  logic [7:0]             ct_addr_r, pt_addr_r, pt_wrdata_r;
  logic [7:0]             s_mem [256];
  logic [7:0]             s_rdata_r, s_addr_s, s_wdata_s;
  logic                   s_we_s;
  logic [7:0]             key_byte_s, i_inc_s, j_ksa_s, j_gen_s;

  assign rdy       = rdy_r;
  assign ct_addr   = ct_addr_r;
  assign pt_addr   = pt_addr_r;
  assign pt_wrdata = pt_wrdata_r;
  assign pt_wren   = pt_wren_r;

  // Key byte selected by the wrapping mod-KEY_BYTES index (byte 0 is the MSB).
  always_comb begin
    key_byte_s = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_byte_s = (kidx_r == KIDX_W'(b)) ? key_r[8*(KEY_BYTES-1-b) +: 8] : key_byte_s;
    end
  end

  // S-box: single port, write has priority, read data arrives one cycle later.
  always_ff @(posedge clk) begin
    if (s_we_s) begin
      s_mem[s_addr_s] <= s_wdata_s;
    end else begin
      s_rdata_r <= s_mem[s_addr_s];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      phase_r <= 3'd0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
    end
  end

  // Next state and S-box port control; the swap sequence is read S[i],
  // read S[j], write S[i], write S[j], then (DROP/PRGA) read the pad.
  always_comb begin
    state_s   = state_r;
    phase_s   = phase_r;
    s_addr_s  = 8'd0;
    s_we_s    = 1'b0;
    s_wdata_s = 8'd0;
    i_inc_s   = i_r + 8'd1;
    j_ksa_s   = j_r + s_rdata_r + key_byte_s;
    j_gen_s   = j_r + s_rdata_r;
    case (state_r)
      ST_IDLE: begin
        phase_s = 3'd0;
        if (en && rdy_r) state_s = ST_INIT;
        else             state_s = ST_IDLE;
      end
      ST_INIT: begin
        s_addr_s  = i_r;
        s_we_s    = 1'b1;
        s_wdata_s = i_r;
        if (i_r == 8'hFF) state_s = ST_KSA;
        else              state_s = ST_INIT;
      end
      ST_KSA: begin
        case (phase_r)
          3'd0: begin s_addr_s = i_r;     phase_s = 3'd1; end
          3'd1: begin s_addr_s = j_ksa_s; phase_s = 3'd2; end
          3'd2: begin s_addr_s = i_r; s_we_s = 1'b1; s_wdata_s = s_rdata_r; phase_s = 3'd3; end
          3'd3: begin
            s_addr_s  = j_r;
            s_we_s    = 1'b1;
            s_wdata_s = si_r;
            phase_s   = 3'd0;
            if (i_r == 8'hFF) state_s = (DROP_N == 0) ? ST_LEN : ST_DROP;
            else              state_s = ST_KSA;
          end
          default: phase_s = 3'd0;
        endcase
      end
      ST_DROP, ST_PRGA: begin
        case (phase_r)
          3'd0: begin s_addr_s = i_inc_s; phase_s = 3'd1; end
          3'd1: begin s_addr_s = j_gen_s; phase_s = 3'd2; end
          3'd2: begin s_addr_s = i_r; s_we_s = 1'b1; s_wdata_s = s_rdata_r; phase_s = 3'd3; end
          3'd3: begin s_addr_s = j_r; s_we_s = 1'b1; s_wdata_s = si_r; phase_s = 3'd4; end
          3'd4: begin s_addr_s = si_r + sj_r; phase_s = 3'd5; end
          3'd5: begin
            phase_s = 3'd0;
            if (state_r == ST_DROP) state_s = (drop_cnt_r == DROP_LAST) ? ST_LEN : ST_DROP;
            else                    state_s = (k_r == len_r) ? ST_DONE : ST_PRGA;
          end
          default: phase_s = 3'd0;
        endcase
      end
      ST_LEN: begin
        case (phase_r)
          3'd0: phase_s = 3'd1;
          3'd1: phase_s = 3'd2;
          3'd2: begin
            phase_s = 3'd0;
            if (ct_rddata == 8'd0) state_s = ST_DONE;
            else                   state_s = ST_PRGA;
          end
          default: phase_s = 3'd0;
        endcase
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath registers and registered outputs; rdy rises the cycle after the last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_r       <= 1'b1;
      pt_wren_r   <= 1'b0;
      ct_addr_r   <= 8'd0;
      pt_addr_r   <= 8'd0;
      pt_wrdata_r <= 8'd0;
      key_r       <= {(8*KEY_BYTES){1'b0}};
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      k_r         <= 8'd0;
      len_r       <= 8'd0;
      kidx_r      <= {KIDX_W{1'b0}};
      drop_cnt_r  <= 12'd0;
    end else begin
      rdy_r     <= (state_s == ST_IDLE);
      pt_wren_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (en && rdy_r) begin
            key_r      <= key;
            i_r        <= 8'd0;
            j_r        <= 8'd0;
            kidx_r     <= {KIDX_W{1'b0}};
            drop_cnt_r <= 12'd0;
          end
        end
        ST_INIT: i_r <= i_inc_s;
        ST_KSA: begin
          case (phase_r)
            3'd1: begin si_r <= s_rdata_r; j_r <= j_ksa_s; end
            3'd3: begin
              i_r    <= i_inc_s;
              kidx_r <= (kidx_r == KIDX_LAST) ? {KIDX_W{1'b0}} : kidx_r + 1'b1;
              // Keystream generation starts from j = 0, as in standard RC4.
              if (i_r == 8'hFF) j_r <= 8'd0;
            end
            default: ;
          endcase
        end
        ST_DROP, ST_PRGA: begin
          case (phase_r)
            3'd0: begin
              i_r <= i_inc_s;
              if (state_r == ST_PRGA) ct_addr_r <= k_r;
            end
            3'd1: begin si_r <= s_rdata_r; j_r <= j_gen_s; end
            3'd2: sj_r <= s_rdata_r;
            3'd5: begin
              if (state_r == ST_DROP) begin
                drop_cnt_r <= drop_cnt_r + 12'd1;
              end else begin
                pt_wren_r   <= 1'b1;
                pt_addr_r   <= k_r;
                pt_wrdata_r <= ct_rddata ^ s_rdata_r;
                k_r         <= k_r + 8'd1;
              end
            end
            default: ;
          endcase
        end
        ST_LEN: begin
          case (phase_r)
            3'd0: ct_addr_r <= 8'd0;
            3'd2: begin
              len_r       <= ct_rddata;
              k_r         <= 8'd1;
              pt_wren_r   <= 1'b1;
              pt_addr_r   <= 8'd0;
              pt_wrdata_r <= ct_rddata;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arc4_engine.sv
// Self-checking bench for arc4_engine: three instances (3/0, 4/0, 6/256)
// checked against known RC4 vectors and a behavioural RC4-drop model.
module tb_arc4_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       en [3];
  logic       rdy [3];
  logic       pt_wren [3];
  logic [7:0] ct_addr [3];
  logic [7:0] ct_rd [3];
  logic [7:0] pt_addr [3];
  logic [7:0] pt_wrdata [3];
  logic [23:0] key_a;
  logic [31:0] key_b;
  logic [47:0] key_c;

  logic [7:0] ct_mem [3][256];
  logic [7:0] pt_mem [3][256];
  logic [7:0] last_wr [3];
  int wr_tot [3]  = '{0, 0, 0};
  int seq_err [3] = '{0, 0, 0};
  int ct_nz [3]   = '{0, 0, 0};

  logic [7:0] key_bytes [32];
  logic [7:0] exp_pt [256];
  logic [7:0] ct_a_vec [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt_a_vec [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_b_vec [6]  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
  logic [7:0] pt_b_vec [6]  = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

  int n_tests = 0;
  int n_fail  = 0;

  arc4_engine #(.KEY_BYTES(3), .DROP_N(0)) u_dut_a (
    .clk(clk), .rst(rst[0]), .en(en[0]), .rdy(rdy[0]), .key(key_a),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rd[0]), .pt_addr(pt_addr[0]),
    .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]));
  arc4_engine #(.KEY_BYTES(4), .DROP_N(0)) u_dut_b (
    .clk(clk), .rst(rst[1]), .en(en[1]), .rdy(rdy[1]), .key(key_b),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rd[1]), .pt_addr(pt_addr[1]),
    .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]));
  arc4_engine #(.KEY_BYTES(6), .DROP_N(256)) u_dut_c (
    .clk(clk), .rst(rst[2]), .en(en[2]), .rdy(rdy[2]), .key(key_c),
    .ct_addr(ct_addr[2]), .ct_rddata(ct_rd[2]), .pt_addr(pt_addr[2]),
    .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]));

  // Synchronous ct RAMs, pt RAMs, and write-order / ct-address monitors.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      ct_rd[u] <= ct_mem[u][ct_addr[u]];
      if (ct_addr[u] != 8'd0) ct_nz[u] <= ct_nz[u] + 1;
      if (pt_wren[u] === 1'b1) begin
        pt_mem[u][pt_addr[u]] <= pt_wrdata[u];
        wr_tot[u] <= wr_tot[u] + 1;
        if (pt_addr[u] != 8'd0 && pt_addr[u] != last_wr[u] + 8'd1) seq_err[u] <= seq_err[u] + 1;
        last_wr[u] <= pt_addr[u];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // RC4-drop[n] reference: plain array arithmetic over the whole buffer.
  task automatic model(input int u, input int kb, input int drop);
    logic [7:0] s [256];
    logic [7:0] t;
    int i, j, len;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + int'(s[x]) + int'(key_bytes[x % kb])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    len = int'(ct_mem[u][0]);
    exp_pt[0] = ct_mem[u][0];
    for (int n = 0; n < drop + len; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (n >= drop) exp_pt[n - drop + 1] = ct_mem[u][n - drop + 1] ^ s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endtask

  task automatic start(input int u);
    en[u] = 1'b1;
    @(negedge clk);
    en[u] = 1'b0;
    check($sformatf("rdy_fall%0d", u), 32'(rdy[u]), 32'd0);
  endtask

  task automatic wait_rdy(input int u, input int bound, input string tag);
    int cyc = 0;
    while (rdy[u] !== 1'b1 && cyc < bound + 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency_ok"}, 32'(cyc <= bound), 32'd1);
  endtask

  initial begin
    int snap_wr, snap_seq, snap_nz;
    logic [31:0] key_b2;
    for (int u = 0; u < 3; u++) begin rst[u] = 1'b1; en[u] = 1'b0; end
    key_a = 24'd0; key_b = 32'd0; key_c = 48'd0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_rdy%0d", u), 32'(rdy[u]), 32'd1);
      check($sformatf("rst_wren%0d", u), 32'(pt_wren[u]), 32'd0);
      check($sformatf("rst_ctaddr%0d", u), 32'(ct_addr[u]), 32'd0);
      check($sformatf("rst_ptaddr%0d", u), 32'(pt_addr[u]), 32'd0);
      check($sformatf("rst_ptdata%0d", u), 32'(pt_wrdata[u]), 32'd0);
      rst[u] = 1'b0;
    end

    // L = 0: one write of pt[0], no ct address other than 0 ever presented.
    ct_mem[0][0] = 8'h00; ct_mem[0][1] = 8'hAA;
    key_a = 24'h4B6579;
    snap_wr = wr_tot[0]; snap_nz = ct_nz[0];
    start(0);
    wait_rdy(0, 256 + 1280 + 3 + 2, "len0");
    check("len0_writes", 32'(wr_tot[0] - snap_wr), 32'd1);
    check("len0_pt0", 32'(pt_mem[0][0]), 32'd0);
    check("len0_no_ct1", 32'(ct_nz[0] - snap_nz), 32'd0);
    check("len0_rdy", 32'(rdy[0]), 32'd1);

    // "Key" / "Plaintext" vector.
    for (int k = 0; k < 10; k++) ct_mem[0][k] = ct_a_vec[k];
    key_bytes[0] = 8'h4B; key_bytes[1] = 8'h65; key_bytes[2] = 8'h79;
    model(0, 3, 0);
    snap_wr = wr_tot[0]; snap_seq = seq_err[0];
    start(0);
    wait_rdy(0, 256 + 1280 + 7*9 + 5, "vecA");
    check("vecA_writes", 32'(wr_tot[0] - snap_wr), 32'd10);
    check("vecA_order", 32'(seq_err[0] - snap_seq), 32'd0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("vecA_pt%0d", k), 32'(pt_mem[0][k]), 32'(pt_a_vec[k]));
      check($sformatf("vecA_model%0d", k), 32'(pt_mem[0][k]), 32'(exp_pt[k]));
    end

    // Reset after pt[3] is written, then a clean rerun.
    snap_wr = wr_tot[0];
    start(0);
    for (int c = 0; c < 3000 && (wr_tot[0] - snap_wr) < 4; c++) @(negedge clk);
    check("rst_mid_reach", 32'(wr_tot[0] - snap_wr), 32'd4);
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst_mid_rdy", 32'(rdy[0]), 32'd1);
    check("rst_mid_wren", 32'(pt_wren[0]), 32'd0);
    check("rst_mid_ctaddr", 32'(ct_addr[0]), 32'd0);
    check("rst_mid_ptaddr", 32'(pt_addr[0]), 32'd0);
    check("rst_mid_ptdata", 32'(pt_wrdata[0]), 32'd0);
    rst[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_mid_nowrite", 32'(wr_tot[0] - snap_wr), 32'd4);
    check("rst_mid_idle", 32'(rdy[0]), 32'd1);
    snap_wr = wr_tot[0];
    start(0);
    wait_rdy(0, 256 + 1280 + 7*9 + 5, "rerun");
    check("rerun_writes", 32'(wr_tot[0] - snap_wr), 32'd10);
    for (int k = 0; k < 10; k++) check($sformatf("rerun_pt%0d", k), 32'(pt_mem[0][k]), 32'(pt_a_vec[k]));

    // Back-to-back with en held; key changes after the first acceptance.
    for (int k = 0; k < 6; k++) ct_mem[1][k] = ct_b_vec[k];
    snap_wr = wr_tot[1]; snap_seq = seq_err[1];
    key_b = 32'h57696B69;
    en[1] = 1'b1;
    @(negedge clk);
    key_b2 = $urandom();
    key_b = key_b2;
    wait_rdy(1, 256 + 1280 + 7*5 + 5, "b2b1");
    check("b2b1_rdy", 32'(rdy[1]), 32'd1);
    check("b2b1_writes", 32'(wr_tot[1] - snap_wr), 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("b2b1_pt%0d", k), 32'(pt_mem[1][k]), 32'(pt_b_vec[k]));
    @(negedge clk);
    check("b2b_rdy_pulse", 32'(rdy[1]), 32'd0);
    en[1] = 1'b0;
    for (int b = 0; b < 4; b++) key_bytes[b] = key_b2[31-8*b -: 8];
    model(1, 4, 0);
    wait_rdy(1, 256 + 1280 + 7*5 + 5, "b2b2");
    check("b2b2_writes", 32'(wr_tot[1] - snap_wr), 32'd12);
    check("b2b_order", 32'(seq_err[1] - snap_seq), 32'd0);
    for (int k = 0; k < 6; k++) check($sformatf("b2b2_pt%0d", k), 32'(pt_mem[1][k]), 32'(exp_pt[k]));

    // RC4-drop256, 6-byte random key, L = 255; en pulsed mid-run is ignored.
    key_c[47:16] = $urandom();
    key_c[15:0]  = 16'($urandom());
    ct_mem[2][0] = 8'hFF;
    for (int k = 1; k < 256; k++) ct_mem[2][k] = 8'($urandom());
    for (int b = 0; b < 6; b++) key_bytes[b] = key_c[47-8*b -: 8];
    model(2, 6, 256);
    snap_wr = wr_tot[2]; snap_seq = seq_err[2];
    start(2);
    key_c = ~key_c;
    repeat (300) @(negedge clk);
    en[2] = 1'b1;
    @(negedge clk);
    en[2] = 1'b0;
    check("drop_busy_rdy", 32'(rdy[2]), 32'd0);
    wait_rdy(2, 256 + 1280 + 7*(256 + 255) + 5, "drop");
    check("drop_writes", 32'(wr_tot[2] - snap_wr), 32'd256);
    check("drop_order", 32'(seq_err[2] - snap_seq), 32'd0);
    for (int k = 0; k < 256; k++) check($sformatf("drop_pt%0d", k), 32'(pt_mem[2][k]), 32'(exp_pt[k]));
    repeat (5) @(negedge clk);
    check("drop_stays_idle", 32'(rdy[2]), 32'd1);
    check("drop_no_extra", 32'(wr_tot[2] - snap_wr), 32'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arc4_engine.md
# arc4_engine

Parametrised ARC4 decryption engine, successor to the fixed 24-bit-key ARC4 top level. It owns its 256-byte S-box, runs state initialisation, key scheduling and keystream generation under a single explicit state machine, and decrypts a length-prefixed ciphertext buffer into a plaintext buffer. The block is instantiated singly in the decrypt datapath or replicated by the key-search wrapper; the en/rdy handshake lets the wrapper launch a new key as soon as the previous one finishes.

## Interface
- KEY_BYTES, 3: key length in bytes, legal range 1..32.
- DROP_N, 0: keystream bytes generated and discarded before the first plaintext byte (RC4-drop[n]), legal range 0..4095.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first); sampled on the accepted en cycle.
- ct_addr  out  8  ciphertext memory address.
- ct_rddata  in  8  ciphertext read data; valid one cycle after ct_addr is presented (synchronous RAM).
- pt_addr  out  8  plaintext memory address.
- pt_wrdata  out  8  plaintext write data.
- pt_wren  out  1  plaintext write strobe, one cycle per byte.

## Operation
- Buffer format: ct[0] = message length L (0..255); ct[1..L] = ciphertext. Output is pt[0] = L, then pt[k] = ct[k] xor pad_k for k = 1..L.
- States: IDLE -> INIT -> KSA -> DROP (skipped if DROP_N=0) -> LEN -> PRGA -> IDLE.
- IDLE: rdy=1. If en=1, latch key into an internal register, clear i and j, and enter INIT.
- INIT: S[i] = i for i = 0..255, one write per cycle.
- KSA: for i = 0..255, j = j + S[i] + keybyte[i mod KEY_BYTES]; then swap S[i] and S[j]. i = j is legal and leaves S unchanged.
- DROP and PRGA: i = i+1, j = j+S[i], swap, pad = S[(S[i]+S[j]) mod 256]. DROP repeats this DROP_N times and discards the pad. i and j carry over into PRGA without being reset.
- LEN: read ct[0] and write pt[0] = L. If L = 0, return to IDLE with no keystream generated.
- PRGA: for k = 1..L, read ct[k] and write pt[k] = ct[k] xor pad.
- Arithmetic: i, j, S-index sums and k are all 8-bit and wrap mod 256. The DROP counter is 12-bit.
- The key mod-index counter wraps at KEY_BYTES, so no divider is needed.
- S is an internal 256x8 array with synchronous read (1-cycle latency) and one port: at most one read or one write per cycle.
- There is no pt read path.

## Timing
- Reset: rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0; state = IDLE.
- Reset mid-operation: IDLE on the next cycle. Any pt bytes already written stay in memory, and no further pt_wren is issued.
- en with rdy=0: ignored, no effect.
- Accepting en: rdy falls on the cycle after the en=1, rdy=1 cycle.
- Completion: rdy rises in the cycle after the final pt_wren (pt[L], or pt[0] if L=0). A new en on that cycle is accepted.
- If en is held high, the next run starts immediately.
- Cycle budget per run: INIT 256 cycles; KSA at most 5 cycles per i; DROP and PRGA at most 7 cycles per byte; LEN at most 3 cycles.
- Total latency at most 256 + 1280 + 7*(DROP_N+L) + 3 + 2 cycles.
- pt writes are strictly in ascending address order, exactly L+1 writes per run.
- The block writes no pt address above L.
- ct_addr changes only in LEN/PRGA; it is otherwise held.
- key may change freely after acceptance without affecting the run.

## Test plan
- KEY_BYTES=3, DROP_N=0, key=24'h4B6579, ct = {09, BB F3 16 E8 D9 40 AF 0A D3} -> pt = {09, 50 6C 61 69 6E 74 65 78 74} ("Plaintext").
  - Check exactly 10 pt_wren pulses, then rdy=1.
- KEY_BYTES=4, key=32'h57696B69, ct = {05, 10 21 BF 04 20} -> pt = {05, 70 65 64 69 61} ("pedia").
- KEY_BYTES=3, ct[0]=00 -> exactly one write, pt[0]=00, then rdy=1.
  - Check the latency bound, and that no ct[1] read is used.
- Back-to-back: hold en=1 across two runs, changing key after the first acceptance.
  - Both outputs must match a reference model.
  - rdy must pulse high for exactly one cycle between runs.
- Assert rst during PRGA after pt[3] is written.
  - No further pt_wren; rdy=1 and all outputs at reset values the next cycle.
  - A fresh run then produces correct output.
- DROP_N=256, KEY_BYTES=6, random key, L=255 -> output matches a software RC4-drop256 model byte-for-byte.
  - k and i wrap past 255 with no write beyond pt[255].
  - en pulsed while rdy=0 is ignored.
